// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator. A horizontal/vertical counter pair walks the
// frame on every pixel clock-enable. The decode of each (h,v) position is
// registered into stage 0 and then shifted through DELAY more stages, so the
// outputs can be lined up with downstream pixel-data latency.
// Line layout: active, front porch, sync, back porch. The counter origin is
// the first visible pixel.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high; overrides everything
//   pix_ce_i      pixel clock enable; counters and outputs advance only on it
//   restart_i     synchronous frame restart (genlock); counters go to (0,0)
//   pix_x_o       horizontal coordinate, 0 when blanked
//   pix_y_o       vertical coordinate, 0 when blanked
//   h_sync_o      horizontal sync, HS_POL level when asserted
//   v_sync_o      vertical sync, VS_POL level when asserted
//   draw_active_o 1 inside the visible region
//   line_start_o  one-pixel strobe at h=0 of every line
//   frame_start_o one-pixel strobe at (0,0)
//   draw_end_o    one-pixel strobe at the last visible pixel
//   screen_end_o  one-pixel strobe at the last pixel of the frame
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int X_W      = 10,
   parameter int Y_W      = 10,
   parameter int DELAY    = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           pix_ce_i,
   input  logic           restart_i,
   output logic [X_W-1:0] pix_x_o,
   output logic [Y_W-1:0] pix_y_o,
   output logic           h_sync_o,
   output logic           v_sync_o,
   output logic           draw_active_o,
   output logic           line_start_o,
   output logic           frame_start_o,
   output logic           draw_end_o,
   output logic           screen_end_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);

   // Idle (deasserted) sync levels; the asserted level is the complement.
   localparam logic HS_IDLE = (HS_POL == 0) ? 1'b1 : 1'b0;
   localparam logic VS_IDLE = (VS_POL == 0) ? 1'b1 : 1'b0;

   if ((2 ** X_W) < H_TOTAL) begin : g_err_x_w
      $error("vga_timing_gen: X_W too narrow for H_TOTAL");
   end
   if ((2 ** Y_W) < V_TOTAL) begin : g_err_y_w
      $error("vga_timing_gen: Y_W too narrow for V_TOTAL");
   end
   if ((DELAY < 0) || (DELAY > 7)) begin : g_err_delay
      $error("vga_timing_gen: DELAY must be 0..7");
   end

   // Sync levels are stored already polarised, so every output is a plain
   // register bit with no logic behind it.
   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic           hs;
      logic           vs;
      logic           act;
      logic           ls;
      logic           fs;
      logic           de;
      logic           se;
   } stage_t;

   localparam stage_t STAGE_RST = '{
      x: '0, y: '0, hs: HS_IDLE, vs: VS_IDLE,
      act: 1'b0, ls: 1'b0, fs: 1'b0, de: 1'b0, se: 1'b0
   };

   logic [X_W-1:0] h_q, h_d;
   logic [Y_W-1:0] v_q, v_d;
   logic [31:0]    h_ext_s;
   logic [31:0]    v_ext_s;
   logic           act_s;
   stage_t         stage_d;
   stage_t         pipe_q [DELAY+1];

   // Counter next state: restart beats pix_ce, wrap at the frame totals.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (restart_i) begin
         h_d = '0;
         v_d = '0;
      end else if (pix_ce_i) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               v_d = '0;
            end else begin
               v_d = v_q + Y_W'(1);
            end
         end else begin
            h_d = h_q + X_W'(1);
            v_d = v_q;
         end
      end else begin
         h_d = h_q;
         v_d = v_q;
      end
   end

   // Decode of the current counter position into the stage-0 word.
   always_comb begin
      h_ext_s    = 32'(h_q);
      v_ext_s    = 32'(v_q);
      act_s      = (h_ext_s < H_ACTIVE) && (v_ext_s < V_ACTIVE);
      stage_d    = STAGE_RST;
      stage_d.x  = act_s ? h_q : '0;
      stage_d.y  = act_s ? v_q : '0;
      stage_d.hs = ((h_ext_s >= H_ACTIVE + H_FP) &&
                    (h_ext_s <  H_ACTIVE + H_FP + H_SYNC)) ? ~HS_IDLE : HS_IDLE;
      stage_d.vs = ((v_ext_s >= V_ACTIVE + V_FP) &&
                    (v_ext_s <  V_ACTIVE + V_FP + V_SYNC)) ? ~VS_IDLE : VS_IDLE;
      stage_d.act = act_s;
      stage_d.ls  = (h_ext_s == 32'd0);
      stage_d.fs  = (h_ext_s == 32'd0) && (v_ext_s == 32'd0);
      stage_d.de  = (h_ext_s == H_ACTIVE - 1) && (v_ext_s == V_ACTIVE - 1);
      stage_d.se  = (h_ext_s == H_TOTAL - 1) && (v_ext_s == V_TOTAL - 1);
   end

   // Position counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Output pipeline; restart leaves in-flight words untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= DELAY; i++) begin
            pipe_q[i] <= STAGE_RST;
         end
      end else if (pix_ce_i) begin
         pipe_q[0] <= stage_d;
         for (int i = 1; i <= DELAY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign pix_x_o       = pipe_q[DELAY].x;
   assign pix_y_o       = pipe_q[DELAY].y;
   assign h_sync_o      = pipe_q[DELAY].hs;
   assign v_sync_o      = pipe_q[DELAY].vs;
   assign draw_active_o = pipe_q[DELAY].act;
   assign line_start_o  = pipe_q[DELAY].ls;
   assign frame_start_o = pipe_q[DELAY].fs;
   assign draw_end_o    = pipe_q[DELAY].de;
   assign screen_end_o  = pipe_q[DELAY].se;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances in a small 16x8 raster: u0 (DELAY=0, active-low syncs) and
// u3 (DELAY=3, active-high syncs), driven by the same stimulus. The driver
// pushes the expected port values of both instances for each pix_ce/rst
// edge into a queue; a monitor pops them after the edge and compares, and on
// idle clocks checks that the outputs held. Window checks on u0 measure
// sync widths, line/frame periods and strobe placement.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;   // 16
   localparam int VT = VA + VF + VS + VB;   // 8
   localparam int XW = 5, YW = 4;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic hs, vs, act, ls, fs, de, se;
   } out_t;

   typedef struct packed {
      out_t a;
      out_t b;
   } pair_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pix_ce = 1'b0;
   logic restart = 1'b0;

   logic [XW-1:0] x0, x3;
   logic [YW-1:0] y0, y3;
   logic hs0, vs0, act0, ls0, fs0, de0, se0;
   logic hs3, vs3, act3, ls3, fs3, de3, se3;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(0), .VS_POL(0), .X_W(XW), .Y_W(YW), .DELAY(0)
   ) u0 (
      .clk(clk), .rst(rst), .pix_ce_i(pix_ce), .restart_i(restart),
      .pix_x_o(x0), .pix_y_o(y0), .h_sync_o(hs0), .v_sync_o(vs0),
      .draw_active_o(act0), .line_start_o(ls0), .frame_start_o(fs0),
      .draw_end_o(de0), .screen_end_o(se0)
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1), .VS_POL(1), .X_W(XW), .Y_W(YW), .DELAY(3)
   ) u3 (
      .clk(clk), .rst(rst), .pix_ce_i(pix_ce), .restart_i(restart),
      .pix_x_o(x3), .pix_y_o(y3), .h_sync_o(hs3), .v_sync_o(vs3),
      .draw_active_o(act3), .line_start_o(ls3), .frame_start_o(fs3),
      .draw_end_o(de3), .screen_end_o(se3)
   );

   int    n_checks = 0;
   int    n_pass   = 0;
   bit    started  = 1'b0;
   bit    win      = 1'b0;
   pair_t exp_q[$];

   // Reference model state: counter position and both pipelines.
   int    mh = 0, mv = 0;
   out_t  m0;
   out_t  m3 [4];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   function automatic out_t rst_val(input bit pol);
      out_t o;
      o    = '0;
      o.hs = ~pol;
      o.vs = ~pol;
      return o;
   endfunction

   function automatic out_t dec(input int h, input int v, input bit pol);
      out_t o;
      bit   a;
      a     = (h < HA) && (v < VA);
      o.x   = a ? XW'(h) : '0;
      o.y   = a ? YW'(v) : '0;
      o.hs  = (h >= HA + HF && h < HA + HF + HS) ? pol : ~pol;
      o.vs  = (v >= VA + VF && v < VA + VF + VS) ? pol : ~pol;
      o.act = a;
      o.ls  = (h == 0);
      o.fs  = (h == 0) && (v == 0);
      o.de  = (h == HA - 1) && (v == VA - 1);
      o.se  = (h == HT - 1) && (v == VT - 1);
      return o;
   endfunction

   // One clock of stimulus; expected post-edge outputs queued on rst/pix_ce.
   task automatic step(input bit r, input bit ce, input bit rs);
      @(negedge clk);
      started = 1'b1;
      rst     = r;
      pix_ce  = ce;
      restart = rs;
      if (r) begin
         mh = 0;
         mv = 0;
         m0 = rst_val(1'b0);
         for (int i = 0; i < 4; i++) m3[i] = rst_val(1'b1);
      end else begin
         if (ce) begin
            for (int i = 3; i > 0; i--) m3[i] = m3[i-1];
            m3[0] = dec(mh, mv, 1'b1);
            m0    = dec(mh, mv, 1'b0);
         end
         if (rs) begin
            mh = 0;
            mv = 0;
         end else if (ce) begin
            mh++;
            if (mh == HT) begin
               mh = 0;
               mv++;
               if (mv == VT) mv = 0;
            end
         end
      end
      if (r || ce) exp_q.push_back('{a: m0, b: m3[3]});
   endtask

   // Monitor: pops on every rst/pix_ce edge, otherwise checks the hold.
   initial begin : monitor
      pair_t cur;
      out_t  got0, got3;
      bit    ev, have, win_prev;
      int    ev_n, last_ls, last_fs, hs_run, vs_run;
      bit    prev_se;
      have = 1'b0; win_prev = 1'b0;
      ev_n = 0; last_ls = -1; last_fs = -1; hs_run = 0; vs_run = 0; prev_se = 1'b0;
      forever begin
         @(posedge clk);
         ev = rst | pix_ce;
         #1;
         if (started) begin
            got0 = '{x: x0, y: y0, hs: hs0, vs: vs0, act: act0, ls: ls0, fs: fs0, de: de0, se: se0};
            got3 = '{x: x3, y: y3, hs: hs3, vs: vs3, act: act3, ls: ls3, fs: fs3, de: de3, se: se3};
            if (ev) begin
               if (exp_q.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
               else begin
                  cur  = exp_q.pop_front();
                  have = 1'b1;
               end
            end
            if (have) begin
               chk(ev ? "d0_out" : "d0_hold", 32'(got0), 32'(cur.a));
               chk(ev ? "d3_out" : "d3_hold", 32'(got3), 32'(cur.b));
            end
            if (win && !win_prev) begin
               ev_n = 0; last_ls = -1; last_fs = -1; hs_run = 0; vs_run = 0; prev_se = 1'b0;
            end
            win_prev = win;
            if (win && ev && !rst) begin
               ev_n++;
               if (hs0 == 1'b0) hs_run++;
               else if (hs_run != 0) begin
                  chk("hsync_width", 32'(hs_run), 32'd3);
                  hs_run = 0;
               end
               if (vs0 == 1'b0) vs_run++;
               else if (vs_run != 0) begin
                  chk("vsync_width", 32'(vs_run), 32'd32);
                  vs_run = 0;
               end
               if (ls0) begin
                  if (last_ls >= 0) chk("line_period", 32'(ev_n - last_ls), 32'd16);
                  last_ls = ev_n;
               end
               if (fs0) begin
                  chk("frame_start_xy", {x0, y0, act0}, {5'd0, 4'd0, 1'b1});
                  if (last_fs >= 0) begin
                     chk("frame_period", 32'(ev_n - last_fs), 32'd128);
                     chk("screen_end_before_fs", 32'(prev_se), 32'd1);
                  end
                  last_fs = ev_n;
               end
               if (de0) chk("draw_end_xy", {x0, y0}, {5'd7, 4'd3});
               prev_se = se0;
            end
         end
      end
   end

   initial begin : driver
      m0 = rst_val(1'b0);
      for (int i = 0; i < 4; i++) m3[i] = rst_val(1'b1);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      // continuous pix_ce, then pix_ce 1-in-4, with timing windows open
      win = 1'b1;
      repeat (300) step(1'b0, 1'b1, 1'b0);
      repeat (130) begin
         step(1'b0, 1'b1, 1'b0);
         repeat (3) step(1'b0, 1'b0, 1'b0);
      end
      win = 1'b0;
      // restart together with pix_ce at (6,2)
      for (int i = 0; i < 200 && !(mh == 6 && mv == 2); i++) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      repeat (40) step(1'b0, 1'b1, 1'b0);
      // restart on an idle clock
      repeat (5) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      repeat (20) step(1'b0, 1'b1, 1'b0);
      // pix_ce stuck low
      repeat (10) step(1'b0, 1'b0, 1'b0);
      // reset mid-line, with pix_ce high on the same edge
      repeat (7) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b1, 1'b0);
      // reset beats restart
      step(1'b1, 1'b0, 1'b1);
      repeat (5) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator that produces pixel coordinates, sync pulses, blanking and frame/line strobes for any mode. Timing is described by porch and sync parameters. Sync polarity is configurable. The generator advances on a pixel clock-enable inside the system clock domain, and a configurable output pipeline delay aligns sync with downstream pixel-data latency. It drives the pixel-generation and framebuffer-read logic of the VGA card.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of h_sync (0 = active-low)
VS_POL, 0, asserted level of v_sync
X_W, 10, width of pix_x and the horizontal counter
Y_W, 10, width of pix_y and the vertical counter
DELAY, 0, extra output pipeline stages (0..7)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
pix_ce  in  1  pixel clock enable; all counters and outputs advance only when 1
restart  in  1  synchronous frame restart (genlock)
pix_x  out  X_W  horizontal pixel coordinate, 0 when blanked
pix_y  out  Y_W  vertical line coordinate, 0 when blanked
h_sync  out  1  horizontal sync at HS_POL when asserted
v_sync  out  1  vertical sync at VS_POL when asserted
draw_active  out  1  1 inside the visible region
line_start  out  1  strobe for the first pixel of every line (h=0)
frame_start  out  1  strobe for pixel (0,0)
draw_end  out  1  strobe for the last visible pixel (H_ACTIVE-1, V_ACTIVE-1)
screen_end  out  1  strobe for the last pixel of the frame (H_TOTAL-1, V_TOTAL-1)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Elaboration error if 2^X_W < H_TOTAL, 2^Y_W < V_TOTAL, or DELAY > 7.
- Line layout is active, then FP, then sync, then BP. The counter origin is the first visible pixel.
- Horizontal counter h (0..H_TOTAL-1):
  - increments on each clk with pix_ce=1;
  - at h=H_TOTAL-1, wraps to 0 and the vertical counter v advances.
- Vertical counter v (0..V_TOTAL-1) wraps to 0 when v=V_TOTAL-1 and h wraps.
- Decode of counter value (h,v):
  - active = h<H_ACTIVE && v<V_ACTIVE
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (changes only at h=0)
  - strobes as listed under Ports
  - pix_x = active ? h : 0; pix_y = active ? v : 0
- Stage 0 output register loads the decode of the current (h,v) on each pix_ce cycle, in the same edge that advances the counters. Coordinates therefore appear 1 pix_ce after the counter holds them.
- DELAY further stages shift on pix_ce only. Total latency from counter to port = 1+DELAY pix_ce events.
- Outputs change only on pix_ce cycles. A strobe stays high for exactly one pixel period (from one pix_ce edge to the next). If pix_ce is stuck at 0, all outputs and counters hold.
- Sync outputs are inverted as needed per HS_POL/VS_POL at the final stage.
- Reset values (counters and all pipeline stages):
  - h=0, v=0
  - pix_x=0, pix_y=0
  - h_sync=~HS_POL, v_sync=~VS_POL
  - draw_active=0, all strobes 0
- First pix_ce after reset loads decode(0,0). With DELAY=0, this gives draw_active=1, line_start=1, frame_start=1, pix_x=0, pix_y=0.
- restart=1 on any clk (independent of pix_ce) forces h=0, v=0. Pipeline contents are untouched. The next pix_ce loads decode(0,0).
- restart together with pix_ce: counters go to 0, not h+1, and the stage-0 register still loads decode of the pre-restart (h,v).
- rst has priority over restart and pix_ce.
- Reset mid-frame returns every output to its reset value in the same edge. No partial strobe survives.

Test Plan:
- Reset, then pix_ce=1 constant, defaults: first output cycle gives pix_x=0, pix_y=0, draw_active=1, frame_start=1. draw_active deasserts after pixel 639 (output cycle 641 after reset).
- Horizontal timing: h_sync low for exactly 96 consecutive pix_ce periods starting at h=656; line period exactly 800; line_start every 800 pix_ce.
- Vertical/frame timing: v_sync low exactly on lines 490–491 (1600 pix_ce); frame_start period 420000 pix_ce; draw_end at (639,479); screen_end at (799,524), one pix_ce before frame_start.
- pix_ce asserted 1 in 4 clk cycles: every output constant across 4 clk cycles; frame period 1,680,000 clk.
- DELAY=3, HS_POL=1, VS_POL=1: all outputs shifted by 3 pix_ce relative to DELAY=0. h_sync is high during sync and low at reset.
- restart asserted at (300,200) with pix_ce: the next output after the in-flight pipeline contents is frame_start with (0,0). rst asserted mid-line returns all outputs to reset values on the next edge.
